// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer and its up-counting sibling.
// Holds the run-state enum and the default counter width.
package countdown_timer_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer; master drives start/pause/reload.
// No backpressure: every input is sampled each rising edge.
interface countdown_timer_if #(
  parameter int WIDTH = countdown_timer_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output start, pause, auto_reload, load_value,
    input  count, busy, done, zero
  );

  modport slave (
    input  start, pause, auto_reload, load_value,
    output count, busy, done, zero
  );

endinterface

// File: rtl/countdown_core.sv
// WIDTH-bit count register with load, hold and saturating decrement; zero/one decode.
// One-edge latency from load/dec to count; no backpressure.
module countdown_core #(
  parameter int WIDTH = countdown_timer_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o,
  output logic             one_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      // Never decrement past zero, so the count cannot wrap to all-ones.
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);
  assign one_o   = (count_q == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with a one-cycle terminal-count pulse and optional auto-reload.
// done rises the cycle after edge E0+N for a start of N at E0; pause stretches that one for one.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   tmr_if
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  logic             core_load;
  logic [WIDTH-1:0] core_load_val;
  logic             core_dec;
  logic             core_zero;
  logic             core_one;
  logic [WIDTH-1:0] core_count;

  countdown_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (core_load),
    .load_val_i (core_load_val),
    .dec_i      (core_dec),
    .count_o    (core_count),
    .zero_o     (core_zero),
    .one_o      (core_one)
  );

  // Priority: start, then pause, then decrement/terminal handling.
  always_comb begin
    state_d       = state_q;
    reload_d      = reload_q;
    done_d        = 1'b0;
    core_load     = 1'b0;
    core_load_val = tmr_if.load_value;
    core_dec      = 1'b0;

    if (tmr_if.start) begin
      core_load = 1'b1;
      if (tmr_if.load_value != '0) begin
        reload_d = tmr_if.load_value;
        state_d  = RUN;
      end else begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end else if ((state_q == RUN) && !tmr_if.pause) begin
      if (core_one) begin
        done_d    = 1'b1;
        core_load = 1'b1;
        if (tmr_if.auto_reload) begin
          core_load_val = reload_q;
        end else begin
          core_load_val = '0;
          state_d       = IDLE;
        end
      end else begin
        core_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign tmr_if.count = core_count;
  assign tmr_if.busy  = (state_q == RUN);
  assign tmr_if.done  = done_q;
  assign tmr_if.zero  = core_zero;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed bench for countdown_timer against a behavioural timer model.
module tb_countdown_timer;

  localparam int W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(W)) tif ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .tmr_if (tif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining ticks, running flag, period, pulse.
  int m_count  = 0;
  bit m_run    = 1'b0;
  int m_reload = 0;
  bit m_done   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count  = 0;
    m_run    = 1'b0;
    m_reload = 0;
    m_done   = 1'b0;
  endtask

  task automatic model_step();
    int lv;
    lv     = int'(tif.load_value);
    m_done = 1'b0;
    if (tif.start) begin
      if (lv == 0) begin
        m_count = 0;
        m_run   = 1'b0;
        m_done  = 1'b1;
      end else begin
        m_reload = lv;
        m_count  = lv;
        m_run    = 1'b1;
      end
    end else if (m_run && !tif.pause) begin
      if (m_count == 1) begin
        m_done = 1'b1;
        if (tif.auto_reload) begin
          m_count = m_reload;
        end else begin
          m_count = 0;
          m_run   = 1'b0;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic compare_model();
    check("count", 32'(tif.count), 32'(m_count));
    check("busy",  32'(tif.busy),  32'(m_run));
    check("done",  32'(tif.done),  32'(m_done));
    check("zero",  32'(tif.zero),  32'(m_count == 0));
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_in(input bit s, input bit p, input bit ar, input int lv);
    tif.start       = s;
    tif.pause       = p;
    tif.auto_reload = ar;
    tif.load_value  = W'(lv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_count", 32'(tif.count), 0);
    check("rst_busy",  32'(tif.busy),  0);
    check("rst_done",  32'(tif.done),  0);
    check("rst_zero",  32'(tif.zero),  1);
    rst = 1'b0;

    // Single shot of 5.
    set_in(1, 0, 0, 5);
    cycle();
    check("ss_load", 32'(tif.count), 5);
    set_in(0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cycle();
      check("ss_count", 32'(tif.count), 32'(5 - i));
      check("ss_done",  32'(tif.done),  32'(i == 5));
      check("ss_busy",  32'(tif.busy),  32'(i != 5));
    end
    cycle();
    check("ss_done_width", 32'(tif.done), 0);

    // Auto-reload of 3.
    set_in(1, 0, 1, 3);
    cycle();
    set_in(0, 0, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      cycle();
      check("ar_count", 32'(tif.count), 32'(3 - (i % 3)));
      check("ar_done",  32'(tif.done),  32'((i % 3) == 0));
    end
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();

    // Pause at 4, then restart with 2 at 3.
    set_in(1, 0, 0, 6);
    cycle();
    set_in(0, 0, 0, 0);
    cycle();
    cycle();
    check("pr_pre", 32'(tif.count), 4);
    set_in(0, 1, 0, 0);
    cycle();
    check("pr_hold1", 32'(tif.count), 4);
    cycle();
    check("pr_hold2", 32'(tif.count), 4);
    set_in(0, 0, 0, 0);
    cycle();
    check("pr_resume", 32'(tif.count), 3);
    set_in(1, 0, 0, 2);
    cycle();
    check("pr_restart", 32'(tif.count), 2);
    check("pr_no_done", 32'(tif.done), 0);
    set_in(0, 0, 0, 0);
    cycle();
    check("pr_done_early", 32'(tif.done), 0);
    cycle();
    check("pr_done", 32'(tif.done), 1);

    // Load of zero from IDLE.
    set_in(1, 0, 0, 0);
    cycle();
    check("z_done", 32'(tif.done), 1);
    check("z_busy", 32'(tif.busy), 0);
    set_in(0, 0, 0, 0);
    cycle();
    check("z_done_clr", 32'(tif.done), 0);

    // Full period of 7.
    set_in(1, 0, 0, 7);
    cycle();
    set_in(0, 0, 0, 0);
    k = 0;
    while (tif.done !== 1'b1 && k < 20) begin
      cycle();
      k++;
    end
    check("full_latency", 32'(k), 7);

    // Start and pause together mid-run: the load wins.
    set_in(1, 0, 0, 6);
    cycle();
    set_in(0, 0, 0, 0);
    cycle();
    set_in(1, 1, 0, 5);
    cycle();
    check("sp_load", 32'(tif.count), 5);

    // Reset mid-count at count 3.
    set_in(0, 0, 0, 0);
    cycle();
    cycle();
    check("mr_pre", 32'(tif.count), 3);
    #2 rst = 1'b1;
    #1;
    check("mr_count", 32'(tif.count), 0);
    check("mr_busy",  32'(tif.busy),  0);
    check("mr_done",  32'(tif.done),  0);
    check("mr_zero",  32'(tif.zero),  1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("mr_idle_count", 32'(tif.count), 0);
      check("mr_idle_done",  32'(tif.done),  0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, int'($urandom_range(0, (1 << W) - 1)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Synchronous, loadable, down-counting timer: the counting-down counterpart of the team's up-counting ripple counter. It loads a programmed value, decrements once per enabled clock, and signals terminal count with a one-cycle pulse, with optional auto-reload for periodic ticks. It sits beside the up counter in the lab datapath and generates timed delays and periodic strobes for the other blocks.

## Interface
- WIDTH, 3: counter width in bits; legal range 2 to 16.
- clock  in  1  rising-edge clock; all state is updated on this edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- start  in  1  load request; sampled each rising edge.
- pause  in  1  holds count and state while in RUN.
- auto_reload  in  1  when high at terminal count, restarts from the reload value instead of stopping.
- load_value  in  WIDTH  start value, captured when start is sampled high.
- count  out  WIDTH  current count (registered).
- busy  out  1  high while in RUN (registered).
- done  out  1  one-cycle terminal-count pulse (registered).
- zero  out  1  combinational decode, count == 0.

## Operation
- Reset values: count=0, busy=0, done=0, zero=1, reload register=0, state IDLE.
- States:
  - IDLE: counter stopped.
  - RUN: decrementing.
- Priority at every edge: start > pause > decrement.
- start while in IDLE or RUN:
  - Load value is nonzero: reload register <= load_value, count <= load_value, state <= RUN, done <= 0. A start in RUN restarts the count and produces no done for the aborted count.
  - Load value is zero: count <= 0, done <= 1 for one cycle, state <= IDLE.
- RUN with pause=1 and start=0: count, state and reload register are held; done=0.
- RUN with pause=0, start=0 and count > 1: count <= count - 1; done=0.
- RUN with pause=0, start=0 and count == 1 (terminal edge): done <= 1.
  - auto_reload=1: count <= reload register, stay in RUN.
  - auto_reload=0: count <= 0, state <= IDLE.
- IDLE with start=0: everything is held and done=0. pause and auto_reload are ignored.
- Arithmetic: unsigned, modulo 2^WIDTH. The count never decrements below 0 and never wraps to all-ones.
- load_value = 2^WIDTH−1 is legal and gives the full period.
- auto_reload is sampled only at the terminal edge. Changing it mid-count has no other effect.

## Timing
- Latency: start sampled at edge E0 with value N ≥ 1 gives count=N after E0, and done high in the cycle after edge E0+N.
- Without auto_reload, busy falls in that same cycle.
- With auto_reload, done repeats every N cycles, and count runs N, N−1, …, 1, N, …. The terminal value 0 never appears in the count.
- done is exactly one cycle wide and never high on two consecutive cycles unless N=1 with auto_reload (a continuous strobe).
- Pause cycles extend the latency one for one.
- Reset asserted mid-count: outputs take their reset values asynchronously and no done is produced. After release, the first edge behaves as IDLE.

## Structure
- Shared package holds:
  - the state enum {IDLE, RUN}
  - the default WIDTH constant, shared with the up counter
- One natural sub-module: countdown_core, the WIDTH-bit register with load, hold, decrement and the zero/one decode.
- The top level holds the FSM, the reload register and done generation.

## Test plan
- Reset: assert reset mid-count (count=3, RUN) -> count=0, busy=0, done=0, zero=1 before the next edge; release, hold start=0 for 4 cycles -> outputs unchanged.
- Single shot: WIDTH=3, start with load_value=5 -> count 5,4,3,2,1,0 on successive cycles; done high only in the cycle count=0; busy falls in that cycle.
- Auto-reload: load_value=3, auto_reload=1 -> count 3,2,1,3,2,1…; done pulses every 3 cycles, coincident with count returning to 3.
- Pause and restart: load_value=6, pause for 2 cycles at count=4 -> count holds 4 for 2 cycles. Then start with load_value=2 at count=3 -> count=2 next cycle, no done for the aborted count, done 2 cycles later.
- Boundaries:
  - load_value=0 -> done pulses next cycle, busy stays 0.
  - load_value=7 -> done exactly 7 cycles after the start edge.
  - start and pause high together -> the load wins.
